// File: rtl/counter_ctl_if.sv
// counter_ctl_if: control/status bundle for counter_ctl
// master drives srst, en, up_dn, load, load_val, limit, mode and reads count, tc, done; slave is the reverse
interface counter_ctl_if #(
    parameter int LENGTH = 10
);
    logic              srst;
    logic              en;
    logic              up_dn;
    logic              load;
    logic [LENGTH-1:0] load_val;
    logic [LENGTH-1:0] limit;
    logic [1:0]        mode;
    logic [LENGTH-1:0] count;
    logic              tc;
    logic              done;
    modport master (
        output srst, en, up_dn, load, load_val, limit, mode,
        input  count, tc, done
    );
    modport slave (
        input  srst, en, up_dn, load, load_val, limit, mode,
        output count, tc, done
    );
endinterface

// File: rtl/counter_ctl.sv
// counter_ctl: up/down counter with runtime limit, sync load/clear and wrap/saturate/one-shot terminal modes
// ports: clk (rising edge), arst_b (async active-low reset), bus (counter_ctl_if.slave: controls in, count/tc/done out, all registered)
module counter_ctl #(
    parameter int          LENGTH = 10,
    parameter int unsigned INIT   = 0
) (
    input logic          clk,
    input logic          arst_b,
    counter_ctl_if.slave bus
);
    localparam logic [LENGTH-1:0] INIT_V = LENGTH'(INIT);
    logic [LENGTH-1:0] count, nxt, term;
    logic              tc, done, one_shot, step, at_end, hold_end;
    always_comb begin
        one_shot = bus.mode == 2'b10;
        step     = bus.en && !(one_shot && done);
        // a count left above a shrunk limit counts as being at the up end
        at_end   = bus.up_dn ? count >= bus.limit : count == '0;
        term     = bus.up_dn ? bus.limit : '0;
        hold_end = bus.mode == 2'b01 || one_shot;
        // saturate/one-shot park on the terminal value; wrap jumps to the opposite end
        nxt      = !at_end ? (bus.up_dn ? count + 1'b1 : count - 1'b1)
                 : hold_end ? term
                 : (bus.up_dn ? '0 : bus.limit);
    end
    always_ff @(posedge clk or negedge arst_b)
        if (!arst_b) begin
            count <= INIT_V;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (bus.srst) begin
            count <= INIT_V;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (bus.load) begin
            count <= bus.load_val < bus.limit ? bus.load_val : bus.limit;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (step) begin
            count <= nxt;
            tc    <= nxt == term && count != term;
            done  <= done | (one_shot && at_end);
        end else
            tc <= 1'b0;
    assign bus.count = count;
    assign bus.tc    = tc;
    assign bus.done  = done;
endmodule

// File: tb/tb_counter_ctl.sv
// tb_counter_ctl: table vectors, corner sequences and random run against a behavioural model
module tb_counter_ctl;
    localparam int L = 4;
    logic clk = 1'b0;
    logic arst_b = 1'b1;
    int nvec = 0;
    int nerr = 0;
    int inits [2] = '{0, 2};
    int mc [2];
    bit mtc [2];
    bit md [2];
    counter_ctl_if #(.LENGTH(L)) bus0 ();
    counter_ctl_if #(.LENGTH(L)) bus1 ();
    assign bus1.srst     = bus0.srst;
    assign bus1.en       = bus0.en;
    assign bus1.up_dn    = bus0.up_dn;
    assign bus1.load     = bus0.load;
    assign bus1.load_val = bus0.load_val;
    assign bus1.limit    = bus0.limit;
    assign bus1.mode     = bus0.mode;
    counter_ctl #(.LENGTH(L), .INIT(0)) u0 (.clk(clk), .arst_b(arst_b), .bus(bus0.slave));
    counter_ctl #(.LENGTH(L), .INIT(2)) u1 (.clk(clk), .arst_b(arst_b), .bus(bus1.slave));
    always #5 clk = ~clk;
    typedef struct {
        bit srst, load, en, up;
        int lv, lim, mode;
        int c;
        bit t, d;
    } vec_t;
    vec_t tbl [$];
    task automatic chk(string nm, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask
    task automatic chk_model(int k, string tag);
        chk($sformatf("%s dut%0d count", tag, k), k == 0 ? int'(bus0.count) : int'(bus1.count), mc[k]);
        chk($sformatf("%s dut%0d tc", tag, k), k == 0 ? int'(bus0.tc) : int'(bus1.tc), int'(mtc[k]));
        chk($sformatf("%s dut%0d done", tag, k), k == 0 ? int'(bus0.done) : int'(bus1.done), int'(md[k]));
    endtask
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mc[k] = inits[k];
            mtc[k] = 0;
            md[k] = 0;
        end
    endtask
    // one clock edge of the spec rules, using the inputs sampled at that edge
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int lim = int'(bus0.limit);
            int lv = int'(bus0.load_val);
            int m = int'(bus0.mode);
            int c = mc[k];
            bit up = bus0.up_dn;
            int t = up ? lim : 0;
            int n;
            if (bus0.srst) begin
                mc[k] = inits[k]; mtc[k] = 0; md[k] = 0;
            end else if (bus0.load) begin
                mc[k] = lv < lim ? lv : lim; mtc[k] = 0; md[k] = 0;
            end else if (!bus0.en || (m == 2 && md[k])) begin
                mtc[k] = 0;
            end else begin
                if (up && c < lim) n = c + 1;
                else if (!up && c > 0) n = c - 1;
                else if (m == 1) n = t;
                else if (m == 2) begin n = t; md[k] = 1; end
                else n = up ? 0 : lim;
                mtc[k] = (n == t) && (c != t);
                mc[k] = n;
            end
        end
    endtask
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask
    task automatic drive(bit srst, bit load, bit en, bit up, int lv, int lim, int mode);
        bus0.srst = srst; bus0.load = load; bus0.en = en; bus0.up_dn = up;
        bus0.load_val = L'(lv); bus0.limit = L'(lim); bus0.mode = 2'(mode);
    endtask
    task automatic async_pulse(string tag);
        arst_b = 1'b0;
        model_reset();
        #1;
        chk_model(0, tag);
        chk_model(1, tag);
        #1 arst_b = 1'b1;
    endtask
    initial begin
        //          srst load en up lv lim mode  c  t d
        tbl.push_back('{0,0,0,1, 0, 5,0,  0,0,0});
        tbl.push_back('{0,0,1,1, 0, 5,0,  1,0,0});
        tbl.push_back('{0,0,1,1, 0, 5,0,  2,0,0});
        tbl.push_back('{0,0,1,1, 0, 5,0,  3,0,0});
        tbl.push_back('{0,0,1,1, 0, 5,0,  4,0,0});
        tbl.push_back('{0,0,1,1, 0, 5,0,  5,1,0});
        tbl.push_back('{0,0,1,1, 0, 5,0,  0,0,0});
        tbl.push_back('{0,0,1,1, 0, 5,0,  1,0,0});
        tbl.push_back('{0,1,1,0, 3, 5,1,  3,0,0});
        tbl.push_back('{0,0,1,0, 0, 5,1,  2,0,0});
        tbl.push_back('{0,0,1,0, 0, 5,1,  1,0,0});
        tbl.push_back('{0,0,1,0, 0, 5,1,  0,1,0});
        tbl.push_back('{0,0,1,0, 0, 5,1,  0,0,0});
        tbl.push_back('{0,0,1,0, 0, 5,1,  0,0,0});
        tbl.push_back('{0,0,1,1, 0, 3,2,  1,0,0});
        tbl.push_back('{0,0,1,1, 0, 3,2,  2,0,0});
        tbl.push_back('{0,0,1,1, 0, 3,2,  3,1,0});
        tbl.push_back('{0,0,1,1, 0, 3,2,  3,0,1});
        tbl.push_back('{0,0,1,1, 0, 3,2,  3,0,1});
        tbl.push_back('{0,0,1,1, 0, 3,2,  3,0,1});
        tbl.push_back('{0,1,1,1, 9, 3,2,  3,0,0});
        tbl.push_back('{1,1,1,1, 5, 3,2,  0,0,0});
        tbl.push_back('{0,1,1,1, 1, 3,2,  1,0,0});
        tbl.push_back('{0,0,1,1, 0, 0,0,  0,1,0});
        tbl.push_back('{0,0,1,1, 0, 0,0,  0,0,0});
        tbl.push_back('{0,0,1,1, 0, 0,2,  0,0,1});
        tbl.push_back('{0,0,1,1, 0, 0,2,  0,0,1});
        tbl.push_back('{0,0,1,0, 0, 0,2,  0,0,1});
        tbl.push_back('{0,1,0,1,15,15,0, 15,0,0});
        tbl.push_back('{0,0,1,1, 0,15,0,  0,0,0});
        tbl.push_back('{0,0,1,0, 0,15,0, 15,0,0});
        tbl.push_back('{0,0,1,0, 0,15,0, 14,0,0});
        tbl.push_back('{0,0,0,0, 0,15,0, 14,0,0});
        tbl.push_back('{0,0,1,1, 0,15,3, 15,1,0});
        tbl.push_back('{0,0,1,1, 0,15,3,  0,0,0});
        tbl.push_back('{0,1,0,1,10,15,1, 10,0,0});
        tbl.push_back('{0,0,1,1, 0, 6,1,  6,1,0});
        tbl.push_back('{0,0,1,1, 0, 6,1,  6,0,0});
        drive(0, 0, 0, 1, 0, 5, 0);
        model_reset();
        #2 arst_b = 1'b0;
        #1;
        chk_model(0, "arst");
        chk_model(1, "arst");
        repeat (2) cycle();
        chk_model(0, "arst held");
        chk_model(1, "arst held");
        #1 arst_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk_model(0, $sformatf("idle%0d", i));
            chk_model(1, $sformatf("idle%0d", i));
        end
        foreach (tbl[i]) begin
            drive(tbl[i].srst, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].lv, tbl[i].lim, tbl[i].mode);
            cycle();
            chk($sformatf("vec%0d count", i), int'(bus0.count), tbl[i].c);
            chk($sformatf("vec%0d tc", i), int'(bus0.tc), int'(tbl[i].t));
            chk($sformatf("vec%0d done", i), int'(bus0.done), int'(tbl[i].d));
            chk_model(1, $sformatf("vec%0d", i));
        end
        drive(0, 1, 0, 1, 12, 15, 0);
        cycle();
        chk("shrink load", int'(bus0.count), 12);
        drive(0, 0, 1, 1, 0, 7, 0);
        cycle();
        chk("shrink count", int'(bus0.count), 0);
        chk("shrink tc", int'(bus0.tc), 0);
        chk_model(1, "shrink");
        repeat (3) cycle();
        chk("midrun count", int'(bus0.count), 3);
        async_pulse("midrun arst");
        cycle();
        chk_model(0, "post arst");
        chk_model(1, "post arst");
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(31) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
                  $urandom_range(1), $urandom_range(15),
                  $urandom_range(3) == 0 ? $urandom_range(15) : $urandom_range(3) + 3 * (i / 200),
                  $urandom_range(3));
            cycle();
            chk_model(0, $sformatf("rnd%0d", i));
            chk_model(1, $sformatf("rnd%0d", i));
            if ($urandom_range(63) == 0) async_pulse($sformatf("rnd%0d arst", i));
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/counter_ctl.md
Name: counter_ctl

Overview:
Parametrised, controllable successor to the free-running binary counter. It adds up/down counting, a runtime terminal limit, synchronous load and clear, and count enable. Three terminal modes are supported: wrap, saturate and one-shot. Registered terminal-count and done flags let it serve as a timer or event divider in verification example designs.

Parameters:
- LENGTH, 10, counter register width in bits (>=2).
- INIT, 0, value loaded by async reset and sync clear; must be < 2**LENGTH.

Ports:
- clk  input  1  clock, rising-edge.
- arst_b  input  1  reset, asynchronous, active-low.
- srst  input  1  synchronous clear, active-high.
- en  input  1  count enable; one step per enabled clk edge.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous load strobe.
- load_val  input  LENGTH  value to load.
- limit  input  LENGTH  terminal value for up counting; range is 0..limit.
- mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- count  output  LENGTH  current counter value (registered).
- tc  output  1  terminal-count pulse (registered).
- done  output  1  one-shot completion flag (registered, sticky).

Behaviour:
- Reset (arst_b=0, async): count=INIT, tc=0, done=0. All outputs are held while arst_b is low. Release is synchronous to the next clk edge.
- Priority per edge: srst > load > en. Inputs are sampled on the rising clk edge.
- srst: count=INIT, tc=0, done=0 on the next edge.
- load: count=min(load_val, limit), done=0, tc=0. en is ignored in that cycle.
- Terminal value T: limit when up_dn=1; 0 when up_dn=0.
- Up step with count < limit: count+1.
- Up step with count >= limit (this includes a count left above a reduced limit):
  - wrap: count goes to 0.
  - saturate: count=limit.
  - one-shot: count=limit, done=1.
- Down step with count > 0: count-1.
- Down step with count = 0:
  - wrap: count goes to limit.
  - saturate: count holds at 0.
  - one-shot: count holds at 0, done=1.
- one-shot with done=1: en steps are ignored and count holds. Only load, srst or reset clear done.
- tc is a one-cycle pulse. It is 1 in the cycle after an enabled step whose next count equals T and whose current count != T.
  - wrap: pulses once per lap.
  - saturate/one-shot: pulses once on arrival only, never while holding.
- tc is 0 whenever en=0, load=1 or srst=1 in the sampled cycle.
- Latency: every output reflects its update one clk edge after the controlling inputs are sampled. There is no combinational path from inputs to outputs.
- limit, mode and up_dn may change on any cycle; they take effect on the next step.
- Arithmetic is unsigned modulo 2**LENGTH internally. Per the rules above, no step ever produces a value outside 0..max(limit, count).
- limit=0: up wrap keeps count at 0 and tc pulses only on arrival from a nonzero value. one-shot sets done on the first enabled step.
- Asserting arst_b mid-count aborts immediately; there is no pending state after release.

Test Plan:
- Reset/defaults: LENGTH=4, INIT=0, arst_b low then high, en=0 for 5 cycles -> count=0, tc=0, done=0 throughout.
- Up wrap: limit=5, mode=00, up_dn=1, en=1 for 14 cycles -> count 1,2,3,4,5,0,1,...; tc high exactly in the cycles count=5 (cycles 5 and 11).
- Down saturate: load=1 with load_val=3, then mode=01, up_dn=0, en=1 for 6 cycles -> count 2,1,0,0,0,0; tc pulses once (cycle count reaches 0).
- One-shot and re-arm: limit=3, mode=10, up_dn=1, en=1 from count=0 -> 1,2,3 with done=1 on 3, then count held at 3 for 4 more cycles. Then load with load_val=9 -> count=3 (clamped), done=0.
- Priority and simultaneous events: srst=1 with load=1 and en=1, INIT=2 -> count=2, done=0, tc=0. Then load=1 with en=1 and load_val=1 -> count=1 with no step.
- Limit shrink and async reset mid-run: count=12, limit changed to 7, up wrap step -> count=0, tc=0. Then arst_b pulsed low between edges -> count=INIT immediately, without waiting for clk.
